// File: rtl/receiver_control.sv
// Receiver side of the Request/Ack serial link: grants words, deserializes 16 bits MSB first
// into a first-word-fall-through FIFO. Optional odd-parity check under RECEIVER_PARITY_EN.
module receiver_control #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Request,
    input  logic          sdrDataIn,
    input  logic          read,
    output logic          Ack,
    output logic [15:0]   rcvData,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          parityErr
);

`ifdef RECEIVER_PARITY_EN
    typedef enum logic [2:0] {IDLE, ACK, SHIFT, PARITY, STORE} state_t;
`else
    typedef enum logic [2:0] {IDLE, ACK, SHIFT, STORE} state_t;
`endif

    localparam logic [AW:0]   DepthCnt = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CntOne   = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne   = AW'(1);

    state_t          state_q, state_d;
    logic [15:0]     shreg_q;
    logic [3:0]      bitcnt_q;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     count_q, count_d;
    logic            empty_q, full_q;
    logic            wr_en, rd_en;

    assign wr_en = (state_q == STORE);
    assign rd_en = read && !empty_q;

    // Only one word is ever in flight and it is stored before IDLE, so count alone tells space.
    always_comb begin
        state_d = state_q;
        Ack     = 1'b0;
        unique case (state_q)
            IDLE:  if (Request && (count_q < DepthCnt)) state_d = ACK;
            ACK: begin
                Ack     = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (bitcnt_q == 4'd15) begin
`ifdef RECEIVER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STORE;
`endif
                end
            end
`ifdef RECEIVER_PARITY_EN
            PARITY: state_d = STORE;
`endif
            STORE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ACK) bitcnt_q <= '0;
            if (state_q == SHIFT) begin
                shreg_q  <= {shreg_q[14:0], sdrDataIn};
                bitcnt_q <= bitcnt_q + 4'd1;
            end
            if (wr_en) begin
                mem[wptr_q] <= shreg_q;
                wptr_q      <= wptr_q + PtrOne;
            end
            if (rd_en) rptr_q <= rptr_q + PtrOne;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == DepthCnt);
        end
    end

`ifdef RECEIVER_PARITY_EN
    logic perr_q;

    // Odd parity: data bits XOR parity bit must be 1.
    always_ff @(posedge clk) begin
        if (Reset) begin
            perr_q <= 1'b0;
        end else if ((state_q == PARITY) && !(^{shreg_q, sdrDataIn})) begin
            perr_q <= 1'b1;
        end
    end

    assign parityErr = perr_q;
`else
    assign parityErr = 1'b0;
`endif

    assign rcvData = mem[rptr_q];
    assign empty   = empty_q;
    assign full    = full_q;
    assign count   = count_q;

endmodule

// File: tb/tb_receiver_control.sv
// Directed bench for receiver_control: acts as the sender and the host.
module tb_receiver_control;
    logic        clk = 1'b0;
    logic        Reset, Request, sdrDataIn, read;
    logic        Ack, empty, full, parityErr;
    logic [15:0] rcvData;
    logic [4:0]  count;

    int total = 0;
    int fails = 0;
    int last_wait = 0;
    int ack_cnt = 0;

    receiver_control #(.DEPTH(16), .AW(4)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Request   (Request),
        .sdrDataIn (sdrDataIn),
        .read      (read),
        .Ack       (Ack),
        .rcvData   (rcvData),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .parityErr (parityErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (Reset) ack_cnt <= 0;
        else if (Ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b1;
        Request = 1'b0;
        read = 1'b0;
        sdrDataIn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;
    endtask

    // Returns at the negedge of the cycle the stored word first becomes visible.
    task automatic send_word(input logic [15:0] w, input logic pbit, input logic pop);
        int n = 0;
        Request = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!Ack && n < 40);
        last_wait = n;
        check("ack_seen", {31'd0, Ack}, 32'd1);
        Request = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk);
            sdrDataIn = w[i];
        end
`ifdef RECEIVER_PARITY_EN
        @(negedge clk);
        sdrDataIn = pbit;
`else
        if (pbit) sdrDataIn = sdrDataIn;
`endif
        @(negedge clk);
        if (pop) read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic pop_one();
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        Request = 1'b0;
        sdrDataIn = 1'b0;
        read = 1'b0;
        do_reset();

        // Reset state
        check("rst_ack", {31'd0, Ack}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_perr", {31'd0, parityErr}, 32'd0);
        check("rst_data", {16'd0, rcvData}, 32'h0000);

        // Single word
        send_word(16'h1000, ~^16'h1000, 1'b0);
        check("w1_latency", last_wait, 32'd1);
        check("w1_data", {16'd0, rcvData}, 32'h1000);
        check("w1_count", {27'd0, count}, 32'd1);
        check("w1_empty", {31'd0, empty}, 32'd0);
        check("w1_acks", ack_cnt, 32'd1);

        // Fill to full, then backpressure
        do_reset();
        for (int i = 0; i < 16; i++) send_word(16'h1000 + 16'(i), ~^(16'h1000 + 16'(i)), 1'b0);
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_count", {27'd0, count}, 32'd16);
        Request = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (Ack) check("stall_ack_low", {31'd0, Ack}, 32'd0);
        end
        check("stall_acks", ack_cnt, 32'd16);
        check("stall_ack_now", {31'd0, Ack}, 32'd0);
        Request = 1'b0;
        check("head_1000", {16'd0, rcvData}, 32'h1000);
        pop_one();
        check("head_1001", {16'd0, rcvData}, 32'h1001);
        check("pop1_full", {31'd0, full}, 32'd0);
        pop_one();
        check("pop2_count", {27'd0, count}, 32'd14);
        send_word(16'h1010, ~^16'h1010, 1'b0);
        send_word(16'h1011, ~^16'h1011, 1'b0);
        check("refill_acks", ack_cnt, 32'd18);
        check("refill_full", {31'd0, full}, 32'd1);

        // Drain across pointer wrap
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_%0d", i), {16'd0, rcvData}, 32'h1002 + i);
            pop_one();
        end
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_count", {27'd0, count}, 32'd0);
        pop_one();
        check("xread_count", {27'd0, count}, 32'd0);
        check("xread_empty", {31'd0, empty}, 32'd1);
        check("xread_rptr", {28'd0, dut.rptr_q}, 32'd2);
        check("xread_wptr", {28'd0, dut.wptr_q}, 32'd2);

        // Simultaneous read and write
        do_reset();
        send_word(16'hB000, ~^16'hB000, 1'b0);
        send_word(16'hB001, ~^16'hB001, 1'b0);
        send_word(16'hB002, ~^16'hB002, 1'b0);
        check("rw_pre_count", {27'd0, count}, 32'd3);
        send_word(16'hB003, ~^16'hB003, 1'b1);
        check("rw_count", {27'd0, count}, 32'd3);
        check("rw_head", {16'd0, rcvData}, 32'hB001);

        // Reset mid-word
        do_reset();
        Request = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!Ack && n < 40);
            check("mid_ack", {31'd0, Ack}, 32'd1);
        end
        Request = 1'b0;
        for (int i = 15; i >= 8; i--) begin
            @(negedge clk);
            sdrDataIn = 1'((16'hA5A5 >> i) & 16'h1);
        end
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        check("mid_count", {27'd0, count}, 32'd0);
        check("mid_state", {29'd0, dut.state_q}, 32'd0);
        check("mid_empty", {31'd0, empty}, 32'd1);
        send_word(16'h5A5A, ~^16'h5A5A, 1'b0);
        check("mid_next_data", {16'd0, rcvData}, 32'h5A5A);
        check("mid_next_count", {27'd0, count}, 32'd1);
        check("perr_default", {31'd0, parityErr}, 32'd0);

`ifdef RECEIVER_PARITY_EN
        do_reset();
        send_word(16'h0001, 1'b0, 1'b0);
        check("par_ok", {31'd0, parityErr}, 32'd0);
        send_word(16'h0003, 1'b0, 1'b0);
        check("par_bad", {31'd0, parityErr}, 32'd1);
        check("par_count", {27'd0, count}, 32'd2);
        pop_one();
        check("par_word", {16'd0, rcvData}, 32'h0003);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
